// File: rtl/serial_add_ctrl_pkg.sv
// Shared sequencer state encoding, reused by sibling controllers.
package serial_add_ctrl_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// Existing 1-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full adder, one bit per clock, LSB first.
// state | meaning
// IDLE  | waiting for start; last result held on sum/cout
// RUN   | one operand bit pair added per edge, carry kept in a flop
// DONE  | result presented, done pulsed for this one cycle
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Shift the new bit in from the top; written this way so WIDTH=1 needs no special case.
    assign res_next = WIDTH'({fa_s, res_sh} >> 1);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_bit) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (start) begin
                a_sh   <= a;
                b_sh   <= b;
                carry  <= cin;
                cnt    <= '0;
                res_sh <= '0;
            end
        end else if (state_q == ST_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            carry  <= fa_cout;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                sum  <= res_next;
                cout <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one add and waits (bounded) for done, then steps back to IDLE.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         output logic seen, output int lat);
        a = ia; b = ib; cin = ic; start = 1'b1;
        tick;
        start = 1'b0;
        seen = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            tick;
            if (done) begin
                seen = 1'b1;
                lat = i;
            end
        end
        if (seen) tick;
    endtask

    task automatic test_reset;
        logic seen;
        int   lat;
        rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); start = 1'($urandom);
            tick;
            checks++;
            if ({busy, done, sum, cout} !== 11'd0) begin
                $display("FAIL reset_hold cycle %0d: busy=%b done=%b sum=%h cout=%b, want all 0",
                         i, busy, done, sum, cout);
                errors++;
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        do_op(8'h01, 8'h02, 1'b0, seen, lat);
        checks++;
        if (!seen || sum !== 8'h03) begin
            $display("FAIL post_reset_op: seen=%b sum=%h, want seen=1 sum=03", seen, sum);
            errors++;
        end
        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            $display("FAIL reset_async: busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy, done, sum, cout);
            errors++;
        end
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL basic_e0: busy=%b done=%b, want busy=1 done=0", busy, done);
            errors++;
        end
        for (int k = 1; k <= 8; k++) begin
            tick;
            checks++;
            if (busy !== 1'b1 || done !== (k == 8)) begin
                $display("FAIL basic_timing E%0d: busy=%b done=%b, want busy=1 done=%b",
                         k, busy, done, (k == 8));
                errors++;
            end
        end
        checks++;
        if (sum !== 8'h4B || cout !== 1'b0) begin
            $display("FAIL basic_result: sum=%h cout=%b, want sum=4b cout=0", sum, cout);
            errors++;
        end
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL basic_e9: busy=%b done=%b, want busy=0 done=0", busy, done);
            errors++;
        end
    endtask

    task automatic test_carry;
        logic seen;
        int   lat;
        do_op(8'hFF, 8'h01, 1'b0, seen, lat);
        checks++;
        if (!seen || lat != 8 || sum !== 8'h00 || cout !== 1'b1) begin
            $display("FAIL carry_ff_01: seen=%b lat=%0d sum=%h cout=%b, want 1 8 00 1",
                     seen, lat, sum, cout);
            errors++;
        end
        do_op(8'hFF, 8'hFF, 1'b1, seen, lat);
        checks++;
        if (!seen || lat != 8 || sum !== 8'hFF || cout !== 1'b1) begin
            $display("FAIL carry_ff_ff_1: seen=%b lat=%0d sum=%h cout=%b, want 1 8 ff 1",
                     seen, lat, sum, cout);
            errors++;
        end
        do_op(8'hA5, 8'h5A, 1'b1, seen, lat);
        checks++;
        if (!seen || sum !== 8'h00 || cout !== 1'b1) begin
            $display("FAIL carry_a5_5a_1: seen=%b sum=%h cout=%b, want 1 00 1",
                     seen, sum, cout);
            errors++;
        end
    endtask

    task automatic test_ignore_busy;
        int dones = 0;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) begin
                a = 8'hAA; b = 8'h55; start = 1'b1;
            end else begin
                start = 1'b0;
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
            tick;
            if (done) dones++;
            if (k == 8) begin
                checks++;
                if (done !== 1'b1 || sum !== 8'h30 || cout !== 1'b0) begin
                    $display("FAIL ignore_result: done=%b sum=%h cout=%b, want 1 30 0",
                             done, sum, cout);
                    errors++;
                end
            end
            if (k == 9) begin
                checks++;
                if (busy !== 1'b0) begin
                    $display("FAIL ignore_busy_fall: busy=%b, want 0", busy);
                    errors++;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (dones != 1 || sum !== 8'h30) begin
            $display("FAIL ignore_single_done: dones=%0d sum=%h, want 1 30", dones, sum);
            errors++;
        end
    endtask

    // DONE returns to IDLE before a held start is seen again, so ops repeat every 10 edges.
    task automatic test_back_to_back;
        int dones = 0;
        a = 8'h01; b = 8'h01; cin = 1'b1; start = 1'b1;
        tick;
        for (int k = 1; k <= 28; k++) begin
            tick;
            if (done) dones++;
            checks++;
            if (done !== ((k % 10) == 8)) begin
                $display("FAIL b2b_done E%0d: done=%b, want %b", k, done, ((k % 10) == 8));
                errors++;
            end
            checks++;
            if (sum !== ((k < 8) ? 8'h30 : 8'h03)) begin
                $display("FAIL b2b_sum E%0d: sum=%h, want %h", k, sum, ((k < 8) ? 8'h30 : 8'h03));
                errors++;
            end
        end
        start = 1'b0;
        tick;
        checks++;
        if (dones != 3 || busy !== 1'b0) begin
            $display("FAIL b2b_count: dones=%0d busy=%b, want 3 0", dones, busy);
            errors++;
        end
    endtask

    task automatic test_abort;
        logic seen;
        int   lat;
        int   dones = 0;
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            $display("FAIL abort_clear: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
                     busy, done, sum, cout);
            errors++;
        end
        tick;
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (done) dones++;
        end
        checks++;
        if (dones != 0 || busy !== 1'b0) begin
            $display("FAIL abort_no_done: dones=%0d busy=%b, want 0 0", dones, busy);
            errors++;
        end
        do_op(8'h80, 8'h80, 1'b0, seen, lat);
        checks++;
        if (!seen || sum !== 8'h00 || cout !== 1'b1) begin
            $display("FAIL abort_rerun: seen=%b sum=%h cout=%b, want 1 00 1", seen, sum, cout);
            errors++;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_ignore_busy;
        test_back_to_back;
        test_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
